// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the registered N-channel arbitrating mux.
// The mode encodings and the wrap-around increment are used by the top level.
package mux_arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // (idx + 1) mod n, written so a non-power-of-two channel count wraps cleanly
    function automatic logic [31:0] wrap_inc(input logic [31:0] idx, input logic [31:0] n);
        logic [31:0] nxt_v;
        nxt_v = idx + 32'd1;
        return (nxt_v >= n) ? 32'd0 : nxt_v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first requesting index at or
// after start, wrapping from N-1 back to 0.
module rr_pick #(
    parameter int N     = 8,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [SEL_W-1:0] idx_s;

    // Scan offsets from the far end so the nearest requester after start is the last one kept.
    always_comb begin
        gnt_idx = '0;
        idx_s   = '0;
        gnt_any = |req;
        for (int k = N - 1; k >= 0; k--) begin
            idx_s   = SEL_W'((int'(start) + k) % N);
            gnt_idx = req[idx_s] ? idx_s : gnt_idx;
        end
    end

endmodule

// File: rtl/mux_arb_reg.sv
// Registered N-channel, W-bit mux with valid/ready on every port; fixed-select
// or round-robin arbitration, one word accepted per cycle into an output register.
module mux_arb_reg
    import mux_arb_pkg::*;
#(
    parameter int N     = 8,
    parameter int W     = 1,
    parameter int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*W-1:0]     in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    output logic [W-1:0]       out_data,
    output logic [SEL_W-1:0]   out_chan,
    output logic               out_valid,
    input  logic               out_ready
);

    // Channel space padded to a power of two so any sel value indexes safely;
    // padded channels are never valid and carry zero data.
    localparam int NP = 1 << SEL_W;

    logic [NP-1:0]    valid_pad_s;
    logic [W-1:0]     chan_s [NP];
    logic [SEL_W-1:0] rr_idx_s;
    logic             rr_any_s;
    logic [SEL_W-1:0] gnt_s;
    logic             gnt_any_s;
    logic             space_s;
    logic             load_s;

    logic [SEL_W-1:0] ptr_r;
    logic [W-1:0]     out_data_r;
    logic [SEL_W-1:0] out_chan_r;
    logic             out_valid_r;

    assign valid_pad_s = NP'(in_valid);

    for (genvar i = 0; i < NP; i++) begin : g_chan
        if (i < N) begin : g_real
            assign chan_s[i] = in_data[i*W +: W];
        end else begin : g_pad
            assign chan_s[i] = '0;
        end
    end

    rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_rr_pick (
        .req     (in_valid),
        .start   (ptr_r),
        .gnt_idx (rr_idx_s),
        .gnt_any (rr_any_s)
    );

    // Mode mux: external select or rotating pointer decides this cycle's grant.
    always_comb begin
        gnt_s     = '0;
        gnt_any_s = 1'b0;
        if (mode == MODE_RR) begin
            gnt_s     = rr_idx_s;
            gnt_any_s = rr_any_s;
        end else begin
            gnt_s     = sel;
            gnt_any_s = valid_pad_s[sel];
        end
    end

    // Space looks at out_ready in the same cycle so a streaming consumer sees no bubbles.
    assign space_s  = ~out_valid_r | out_ready;
    assign load_s   = gnt_any_s & space_s;
    assign in_ready = load_s ? (N'(1'b1) << gnt_s) : '0;

    // Output register: capture the granted word, drain on accept, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= '0;
            out_chan_r  <= '0;
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            out_data_r  <= chan_s[gnt_s];
            out_chan_r  <= gnt_s;
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Round-robin pointer advances past the winner only in round-robin mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (load_s && (mode == MODE_RR)) begin
            ptr_r <= SEL_W'(wrap_inc(32'(gnt_s), 32'(N)));
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign out_data  = out_data_r;
    assign out_chan  = out_chan_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_mux_arb_reg.sv
// Randomised and directed bench for mux_arb_reg: an 8-channel and a 5-channel
// instance run side by side against a behavioural grant/output model.
module tb_mux_arb_reg;

    logic        clk;
    logic        rst_n;

    logic [63:0] in_data8;
    logic [7:0]  in_valid8;
    logic [7:0]  in_ready8;
    logic        mode8;
    logic [2:0]  sel8;
    logic [7:0]  out_data8;
    logic [2:0]  out_chan8;
    logic        out_valid8;
    logic        out_ready8;

    logic [39:0] in_data5;
    logic [4:0]  in_valid5;
    logic [4:0]  in_ready5;
    logic        mode5;
    logic [2:0]  sel5;
    logic [7:0]  out_data5;
    logic [2:0]  out_chan5;
    logic        out_valid5;
    logic        out_ready5;

    int nvec  = 0;
    int nfail = 0;

    // model state: index 0 is the 8-channel instance, index 1 the 5-channel one
    int         m_ptr [2];
    logic       m_val [2];
    logic [7:0] m_dat [2];
    int         m_chn [2];

    mux_arb_reg #(.N(8), .W(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data8),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .mode      (mode8),
        .sel       (sel8),
        .out_data  (out_data8),
        .out_chan  (out_chan8),
        .out_valid (out_valid8),
        .out_ready (out_ready8)
    );

    mux_arb_reg #(.N(5), .W(8)) u_dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data5),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .mode      (mode5),
        .sel       (sel5),
        .out_data  (out_data5),
        .out_chan  (out_chan5),
        .out_valid (out_valid5),
        .out_ready (out_ready5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Grant from the rules: fixed picks sel if in range and valid; round-robin
    // picks the first valid channel walking upward from the pointer.
    function automatic int model_grant(input int n, input logic m, input int s,
                                       input logic [7:0] v, input int p);
        if (m == 1'b0) begin
            return (s < n && v[s] == 1'b1) ? s : -1;
        end
        for (int k = 0; k < n; k++) begin
            if (v[(p + k) % n] == 1'b1) return (p + k) % n;
        end
        return -1;
    endfunction

    task automatic step();
        int         g [2];
        bit         ld [2];
        int         n [2];
        logic [7:0] v [2];
        logic       mo [2];
        int         s [2];
        logic       ordy [2];
        #1;
        n[0] = 8;  n[1] = 5;
        v[0] = in_valid8;  v[1] = {3'b000, in_valid5};
        mo[0] = mode8;     mo[1] = mode5;
        s[0] = int'(sel8); s[1] = int'(sel5);
        ordy[0] = out_ready8; ordy[1] = out_ready5;
        for (int d = 0; d < 2; d++) begin
            g[d]  = model_grant(n[d], mo[d], s[d], v[d], m_ptr[d]);
            ld[d] = (g[d] >= 0) && (!m_val[d] || ordy[d]);
        end
        check_eq("rdy8", 32'(in_ready8), ld[0] ? (32'd1 << g[0]) : 32'd0);
        check_eq("rdy5", 32'(in_ready5), ld[1] ? (32'd1 << g[1]) : 32'd0);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (ld[d]) begin
                m_val[d] = 1'b1;
                m_dat[d] = (d == 0) ? 8'(in_data8 >> (8 * g[d])) : 8'(in_data5 >> (8 * g[d]));
                m_chn[d] = g[d];
                if (mo[d] == 1'b1) m_ptr[d] = (g[d] + 1) % n[d];
            end else if (ordy[d]) begin
                m_val[d] = 1'b0;
            end
        end
        #1;
        check_eq("valid8", 32'(out_valid8), 32'(m_val[0]));
        check_eq("data8",  32'(out_data8),  32'(m_dat[0]));
        check_eq("chan8",  32'(out_chan8),  32'(m_chn[0]));
        check_eq("valid5", 32'(out_valid5), 32'(m_val[1]));
        check_eq("data5",  32'(out_data5),  32'(m_dat[1]));
        check_eq("chan5",  32'(out_chan5),  32'(m_chn[1]));
    endtask

    task automatic do_reset();
        in_valid8 = 8'h00;
        in_valid5 = 5'h00;
        rst_n     = 1'b0;
        #2;
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0; m_val[d] = 1'b0; m_dat[d] = 8'h00; m_chn[d] = 0;
        end
        check_eq("rst_valid8", 32'(out_valid8), 32'd0);
        check_eq("rst_data8",  32'(out_data8),  32'd0);
        check_eq("rst_chan8",  32'(out_chan8),  32'd0);
        check_eq("rst_rdy8",   32'(in_ready8),  32'd0);
        check_eq("rst_valid5", 32'(out_valid5), 32'd0);
        check_eq("rst_rdy5",   32'(in_ready5),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] held;
        int         exp5 [4];
        exp5[0] = 1; exp5[1] = 4; exp5[2] = 1; exp5[3] = 4;
        in_data8 = 64'h0; mode8 = 1'b1; sel8 = 3'd0; out_ready8 = 1'b1;
        in_data5 = 40'h0; mode5 = 1'b1; sel5 = 3'd0; out_ready5 = 1'b1;
        do_reset();

        // fixed select
        mode8 = 1'b0; sel8 = 3'd5;
        in_data8 = {$urandom, $urandom};
        in_data8[47:40] = 8'hA5;
        in_valid8 = 8'b0010_1001;
        #1;
        check_eq("fix_rdy", 32'(in_ready8), 32'h20);
        step();
        check_eq("fix_data", 32'(out_data8), 32'hA5);
        check_eq("fix_chan", 32'(out_chan8), 32'd5);
        sel8 = 3'd6;
        #1;
        check_eq("fix_inv_rdy", 32'(in_ready8), 32'h00);
        step();

        // round-robin fairness, no bubbles
        mode8 = 1'b1; in_valid8 = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            in_data8 = {$urandom, $urandom};
            step();
            check_eq("rr_chan",  32'(out_chan8),  32'(i % 8));
            check_eq("rr_valid", 32'(out_valid8), 32'd1);
        end

        // reset while a word is held, then round-robin restarts at channel 0
        check_eq("pre_rst_valid", 32'(out_valid8), 32'd1);
        do_reset();
        in_valid8 = 8'hFF;
        in_data8 = {$urandom, $urandom};
        step();
        check_eq("post_rst_chan", 32'(out_chan8), 32'd0);

        // N=5 skipping and wrap
        mode5 = 1'b1; in_valid5 = 5'b10010;
        for (int i = 0; i < 4; i++) begin
            in_data5 = {$urandom, 8'($urandom)};
            step();
            check_eq("rr5_chan", 32'(out_chan5), 32'(exp5[i]));
        end
        in_valid5 = 5'b00011;
        step();
        check_eq("wrap5_chan", 32'(out_chan5), 32'd0);

        // backpressure
        in_valid8 = 8'hFF; out_ready8 = 1'b1;
        step();
        held = out_data8;
        out_ready8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data8 = {$urandom, $urandom};
            step();
            check_eq("bp_data",  32'(out_data8),  32'(held));
            check_eq("bp_valid", 32'(out_valid8), 32'd1);
        end
        out_ready8 = 1'b1;
        step();
        check_eq("bp_reload_valid", 32'(out_valid8), 32'd1);

        // mode switch resumes round-robin from the stored pointer
        do_reset();
        mode8 = 1'b1; in_valid8 = 8'b0000_0100;
        step();
        check_eq("sw_rr_chan", 32'(out_chan8), 32'd2);
        mode8 = 1'b0; sel8 = 3'd0; in_valid8 = 8'hFF;
        step();
        step();
        check_eq("sw_fix_chan", 32'(out_chan8), 32'd0);
        mode8 = 1'b1;
        step();
        check_eq("sw_back_chan", 32'(out_chan8), 32'd3);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            in_data8   = {$urandom, $urandom};
            in_valid8  = 8'($urandom) & 8'($urandom);
            mode8      = 1'($urandom);
            sel8       = 3'($urandom);
            out_ready8 = ($urandom_range(0, 3) != 0);
            in_data5   = {$urandom, 8'($urandom)};
            in_valid5  = 5'($urandom) & 5'($urandom);
            mode5      = 1'($urandom);
            sel5       = 3'($urandom);
            out_ready5 = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/mux_arb_reg.md
# mux_arb_reg

Parametrised, registered N-channel, W-bit multiplexer with valid/ready handshakes on every input and on the output. It sits between several producer channels and one consumer. It supports two modes: fixed select, where an external `sel` picks the channel, and round-robin, where an internal rotating pointer arbitrates among valid channels. One word is accepted per cycle, and the result is held in an output register until the consumer takes it.

## Interface
- `N`, default 8: channel count, N ≥ 2.
- `W`, default 1: data width per channel, W ≥ 1.
- `SEL_W`, default $clog2(N): select and pointer width. Derived; never overridden.
- `clk`, input, 1: sole clock, rising edge.
- `rst_n`, input, 1: reset. One clock; reset is asynchronous and active-low.
- `in_data`, input, N*W: channel i occupies bits [i*W +: W].
- `in_valid`, input, N: channel i has a word.
- `in_ready`, output, N: channel i's word is taken this cycle. One-hot or zero.
- `mode`, input, 1: 0 = fixed select, 1 = round-robin.
- `sel`, input, SEL_W: channel index used in fixed mode.
- `out_data`, output, W: registered output word.
- `out_chan`, output, SEL_W: index of the channel that supplied `out_data`.
- `out_valid`, output, 1: output register holds an untaken word.
- `out_ready`, input, 1: consumer accepts `out_data` this cycle.

## Operation
- Grant is combinational each cycle:
  - Fixed mode: the grant is `sel` if `sel` < N and `in_valid[sel]`=1. Otherwise there is no grant.
  - Round-robin mode: the grant is the lowest index at or after `ptr` (wrapping N-1 → 0) whose `in_valid` is 1. There is no grant if `in_valid`=0.
- `space` = !`out_valid` | `out_ready`.
- `load` = grant present & `space`.
- `in_ready[g]` = `load` for the granted channel g. All other bits are 0.
- On `load`:
  - `out_data` ← the granted channel's word.
  - `out_chan` ← g.
  - `out_valid` ← 1.
- With no `load` and `out_ready`=1: `out_valid` ← 0. `out_data` and `out_chan` keep their values.
- With no `load` and `out_ready`=0: all outputs hold.
- `ptr` (SEL_W bits, internal):
  - In round-robin mode, on `load`, `ptr` ← (g+1) mod N. The value N-1 wraps to 0, including when N is not a power of two.
  - In fixed mode, `ptr` never changes. On a switch back to round-robin, arbitration resumes from the stored `ptr`.
- `mode` and `sel` may change on any cycle and take effect in that cycle's grant. A word already in the output register is unaffected.
- Inputs are not required to hold `in_data` stable while waiting. The block samples data only on the `load` edge.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - `out_valid`=0, `out_data`=0, `out_chan`=0, `ptr`=0.
  - `in_ready`=0, because `load` cannot occur with no grant. If a grant does exist, `in_ready` may assert in the first cycle after release.
- Latency: an input is accepted at edge k, and `out_valid`/`out_data` are visible after edge k.
- Throughput: 1 word per cycle with `out_ready` held at 1. There are no bubbles, because `space` sees `out_ready` in the same cycle.
- Backpressure: with `out_ready`=0 and `out_valid`=1, every `in_ready` is 0 and the output is stable.
- Reset mid-transfer: the held word is discarded and `ptr` returns to 0. No partial state survives.
- When all `in_valid` are 0 and `out_ready`=1, `out_valid` falls after the edge.

## Structure
- Package `mux_arb_pkg` holds:
  - Constants `MODE_FIXED`=1'b0 and `MODE_RR`=1'b1.
  - A function `wrap_inc(idx, n)` returning (idx+1) mod n.
- One sub-module, `rr_pick`, parametrised by N. It is purely combinational and handles round-robin only.
  - Inputs: `req[N]` and `start[SEL_W]`.
  - Outputs: `gnt_idx[SEL_W]` and `gnt_any`.
- The top level holds the mode mux, the output register and `ptr`.

## Test plan
- Reset and idle (N=8, W=8): assert `rst_n`=0 mid-stream with `out_valid`=1. Required: all outputs go to 0 immediately, and a round-robin grant after release starts at channel 0.
- Fixed mode (N=8, W=8): `sel`=5 with `in_data` channel 5 = 8'hA5, and channels 0, 3 and 5 valid. Required: `in_ready`=8'b0010_0000; next cycle `out_data`=8'hA5 and `out_chan`=5. Then `sel`=6 with channel 6 invalid: required `in_ready`=0.
- Round-robin fairness (N=8, W=8): `in_valid`=8'hFF held, `out_ready`=1. Required: `out_chan` sequence 0,1,…,7,0 on consecutive cycles with no bubbles.
- Round-robin skipping and wrap (N=5, non-power-of-two): only channels 1 and 4 valid. Required: grants 1,4,1,4. After channel 4, `ptr` wraps to 0, not to 5.
- Backpressure (N=8, W=8): `out_ready`=0 for 3 cycles with `out_valid`=1. Required: `in_ready`=0 and `out_data` stable throughout. `out_ready`=1 with a pending request reloads in the same cycle and `out_valid` stays 1.
- Mode switch (N=8, W=8): in round-robin, grant channel 2; switch to fixed with `sel`=0 for two transfers; switch back. Required: the next round-robin grant searches from channel 3.
